control_sequencer: RTL and testbench
====================================

# control_sequencer

Hardwired control unit for the RISC CPU datapath. It is the parametrised successor to hand-sequenced, per-instruction control stimulus. One FSM fetches, decodes and executes load (ld), load-immediate (ldi), store (st), register ALU and halt instructions. It drives the existing DataPath control inputs and waits on a memory-ready handshake instead of fixed single-cycle RAM access. It sits between the instruction register and the DataPath, replacing external per-cycle control.

## Interface
- IR_W, 32, instruction width; opcode is ir[IR_W-1 -: OPC_W].
- OPC_W, 5, opcode width.
- ALU_W, 5, width of aluControl.
- ALU_ADD, 5'b00011, aluControl code used for address/immediate add.
- ALU_LO, 5'b00011, lowest register-ALU opcode (inclusive).
- ALU_HI, 5'b01100, highest register-ALU opcode (inclusive).
- OP_LD / OP_LDI / OP_ST / OP_HALT, 5'b00000 / 5'b00001 / 5'b00010 / 5'b11011.

Ports:
- clock  in  1  system clock; all state changes on rising edge.
- clear  in  1  reset, asynchronous, active-high.
- run  in  1  permits a new fetch; sampled only in T0.
- ir  in  IR_W  current IR contents.
- mem_ready  in  1  memory completes the current read/write this cycle.
- PCout, IncPC, MARin, MDRin, MDRout, IRin, Yin, Cout, ZLOin, ZLOout, ZMuxEnable, ZSelect  out  1 each  DataPath controls.
- Gra, Grb, Grc, Rin, Rout, BAout  out  1 each  register select/enable.
- read, write, RAMenable  out  1 each  memory controls.
- aluControl  out  ALU_W  ALU operation.
- halted  out  1  high in HALT.
- illegal  out  1  one-cycle pulse on an undefined opcode.
- state  out  4  debug encoding: RESET=0, T0..T7=1..8, HALT=9.

## Operation
- Control outputs are decoded combinationally from the state register plus the latched opcode. Unlisted outputs are 0. ZSelect is always 0.
- The opcode is captured from ir at the end of T2 (with IRin) into an internal register. Decode from T3 onward uses only this register.
- Fetch (all opcodes):
  - T0: PCout, MARin, IncPC. If run=0, stay in T0 with all outputs 0.
  - T1: read, RAMenable asserted. MDRin is high only in a cycle where mem_ready=1; advance only then.
  - T2: MDRout, IRin.
- ld: T3 Grb, BAout, Yin. T4 Cout, aluControl=ALU_ADD, ZMuxEnable, ZLOin. T5 ZLOout, MARin. T6 memory read as in T1. T7 MDRout, Gra, Rin. Then T0.
- ldi: T3, T4 as ld. T5 ZLOout, Gra, Rin. Then T0.
- st: T3–T5 as ld. T6 Gra, Rout, MDRin (read=0, MDR loads from bus). T7 write, RAMenable held until mem_ready=1. Then T0.
- ALU (ALU_LO ≤ op ≤ ALU_HI):
  - T3: Grb, Rout, Yin.
  - T4: Grc, Rout, aluControl=opcode, ZMuxEnable, ZLOin.
  - T5: ZLOout, Gra, Rin. Then T0.
- halt: T3 goes to HALT. HALT is exited only by clear.
- Other opcodes: T3 asserts illegal and returns to T0. No register or memory writes occur.

## Timing
- clear asserted: state=RESET, latched opcode=0, all outputs 0, asynchronously. This also applies mid-instruction and mid-memory-wait; a pending write is dropped immediately.
- First rising edge with clear=0: RESET→T0.
- T0 with run=1 always takes exactly 1 cycle.
- Memory states (T1; T6 for ld; T7 for st) last 1+N cycles, where N is the number of cycles mem_ready=0. If mem_ready=1 on entry, the state lasts 1 cycle.
- mem_ready is ignored outside memory states.
- Zero-wait latencies from T0 entry back to T0 entry:
  - ld and st: 8 cycles.
  - ldi and ALU: 6 cycles.
  - illegal: 4 cycles.
- HALT is reached 4 cycles after T0 entry. halted rises in the cycle state=9 and stays high.
- Changes on ir outside the T2 capture edge have no effect on the running instruction.
- run deasserted mid-instruction does not stall it; the stop takes effect at the next T0.

## Test plan
- ld R2,0x45(R1) (ir=0x01080045), mem_ready tied 1: state sequence 1..8 then 1. T4 aluControl=00011. T7 has Gra=Rin=MDRout=1. Total 8 cycles.
- add R5,R2,R4 (ir=0x1A920000): T4 aluControl=00011 with Grc=Rout=ZLOin=1. Returns to T0 after T5; 6 cycles.
- st R3,0x87 (ir=0x11800087), mem_ready low for 3 cycles in T7: write=RAMenable=1 held for 4 cycles, then T0. Total 11 cycles.
- Fetch with mem_ready low 2 cycles in T1: MDRin=0 for 2 cycles, then 1 for one cycle, then T2.
- ir=0xD8000000: halted=1 from cycle 5 onward. It stays in HALT for 20 cycles even with run=1. Asserting clear gives state=0 and halted=0 immediately.
- ir=0xF8000000 (opcode 11111): illegal pulses for exactly 1 cycle at T3, no Rin/write asserted, returns to T0. Separately, clear during ld T6 zeroes all outputs and restarts from RESET.

Source files
------------

// File: rtl/control_sequencer_if.sv
// rtl/control_sequencer_if.sv - instruction/memory inputs and DataPath control outputs of the sequencer
interface control_sequencer_if #(
  parameter int IR_W  = 32,
  parameter int ALU_W = 5
);
  logic             run;
  logic [IR_W-1:0]  ir;
  logic             mem_ready;
  logic             PCout, IncPC, MARin, MDRin, MDRout, IRin, Yin, Cout;
  logic             ZLOin, ZLOout, ZMuxEnable, ZSelect;
  logic             Gra, Grb, Grc, Rin, Rout, BAout;
  logic             read, write, RAMenable;
  logic [ALU_W-1:0] aluControl;
  logic             halted, illegal;
  logic [3:0]       state;

  modport master (
    input  run, ir, mem_ready,
    output PCout, IncPC, MARin, MDRin, MDRout, IRin, Yin, Cout,
           ZLOin, ZLOout, ZMuxEnable, ZSelect,
           Gra, Grb, Grc, Rin, Rout, BAout,
           read, write, RAMenable, aluControl, halted, illegal, state
  );

  modport slave (
    output run, ir, mem_ready,
    input  PCout, IncPC, MARin, MDRin, MDRout, IRin, Yin, Cout,
           ZLOin, ZLOout, ZMuxEnable, ZSelect,
           Gra, Grb, Grc, Rin, Rout, BAout,
           read, write, RAMenable, aluControl, halted, illegal, state
  );
endinterface

// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - hardwired fetch/decode/execute FSM driving the RISC DataPath
module control_sequencer #(
  parameter int               IR_W    = 32,
  parameter int               OPC_W   = 5,
  parameter int               ALU_W   = 5,
  parameter logic [ALU_W-1:0] ALU_ADD = 5'b00011,
  parameter logic [OPC_W-1:0] ALU_LO  = 5'b00011,
  parameter logic [OPC_W-1:0] ALU_HI  = 5'b01100,
  parameter logic [OPC_W-1:0] OP_LD   = 5'b00000,
  parameter logic [OPC_W-1:0] OP_LDI  = 5'b00001,
  parameter logic [OPC_W-1:0] OP_ST   = 5'b00010,
  parameter logic [OPC_W-1:0] OP_HALT = 5'b11011
) (
  input  logic                 clock,
  input  logic                 clear,
  control_sequencer_if.master  bus
);

  typedef enum logic [3:0] {
    S_RESET = 4'd0,
    S_T0    = 4'd1,
    S_T1    = 4'd2,
    S_T2    = 4'd3,
    S_T3    = 4'd4,
    S_T4    = 4'd5,
    S_T5    = 4'd6,
    S_T6    = 4'd7,
    S_T7    = 4'd8,
    S_HALT  = 4'd9
  } state_t;

  state_t           state_q, state_d;
  logic [OPC_W-1:0] opc_q, opc_d;
  logic             is_ldst, is_alu, is_mem_op;

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q <= S_RESET;
      opc_q   <= '0;
    end else begin
      state_q <= state_d;
      opc_q   <= opc_d;
    end
  end

  // Decode uses only the opcode latched with IRin, never the live ir bus.
  assign is_ldst   = (opc_q == OP_LD) || (opc_q == OP_LDI) || (opc_q == OP_ST);
  assign is_alu    = (opc_q >= ALU_LO) && (opc_q <= ALU_HI);
  assign is_mem_op = (opc_q == OP_LD) || (opc_q == OP_ST);

  always_comb begin
    state_d        = state_q;
    opc_d          = opc_q;
    bus.PCout      = 1'b0;
    bus.IncPC      = 1'b0;
    bus.MARin      = 1'b0;
    bus.MDRin      = 1'b0;
    bus.MDRout     = 1'b0;
    bus.IRin       = 1'b0;
    bus.Yin        = 1'b0;
    bus.Cout       = 1'b0;
    bus.ZLOin      = 1'b0;
    bus.ZLOout     = 1'b0;
    bus.ZMuxEnable = 1'b0;
    bus.ZSelect    = 1'b0;
    bus.Gra        = 1'b0;
    bus.Grb        = 1'b0;
    bus.Grc        = 1'b0;
    bus.Rin        = 1'b0;
    bus.Rout       = 1'b0;
    bus.BAout      = 1'b0;
    bus.read       = 1'b0;
    bus.write      = 1'b0;
    bus.RAMenable  = 1'b0;
    bus.aluControl = '0;
    bus.halted     = 1'b0;
    bus.illegal    = 1'b0;
    bus.state      = state_q;

    case (state_q)
      S_RESET: state_d = S_T0;
      S_T0: begin
        if (bus.run) begin
          bus.PCout = 1'b1;
          bus.MARin = 1'b1;
          bus.IncPC = 1'b1;
          state_d   = S_T1;
        end
      end
      S_T1: begin
        bus.read      = 1'b1;
        bus.RAMenable = 1'b1;
        if (bus.mem_ready) begin
          bus.MDRin = 1'b1;
          state_d   = S_T2;
        end
      end
      S_T2: begin
        bus.MDRout = 1'b1;
        bus.IRin   = 1'b1;
        opc_d      = bus.ir[IR_W-1 -: OPC_W];
        state_d    = S_T3;
      end
      S_T3: begin
        if (is_ldst) begin
          bus.Grb   = 1'b1;
          bus.BAout = 1'b1;
          bus.Yin   = 1'b1;
          state_d   = S_T4;
        end else if (is_alu) begin
          bus.Grb  = 1'b1;
          bus.Rout = 1'b1;
          bus.Yin  = 1'b1;
          state_d  = S_T4;
        end else if (opc_q == OP_HALT) begin
          state_d = S_HALT;
        end else begin
          bus.illegal = 1'b1;
          state_d     = S_T0;
        end
      end
      S_T4: begin
        bus.ZMuxEnable = 1'b1;
        bus.ZLOin      = 1'b1;
        if (is_ldst) begin
          bus.Cout       = 1'b1;
          bus.aluControl = ALU_ADD;
        end else begin
          bus.Grc        = 1'b1;
          bus.Rout       = 1'b1;
          bus.aluControl = ALU_W'(opc_q);
        end
        state_d = S_T5;
      end
      S_T5: begin
        bus.ZLOout = 1'b1;
        if (is_mem_op) begin
          bus.MARin = 1'b1;
          state_d   = S_T6;
        end else begin
          bus.Gra = 1'b1;
          bus.Rin = 1'b1;
          state_d = S_T0;
        end
      end
      S_T6: begin
        if (opc_q == OP_ST) begin
          bus.Gra   = 1'b1;
          bus.Rout  = 1'b1;
          bus.MDRin = 1'b1;
          state_d   = S_T7;
        end else begin
          bus.read      = 1'b1;
          bus.RAMenable = 1'b1;
          if (bus.mem_ready) begin
            bus.MDRin = 1'b1;
            state_d   = S_T7;
          end
        end
      end
      S_T7: begin
        if (opc_q == OP_ST) begin
          bus.write     = 1'b1;
          bus.RAMenable = 1'b1;
          if (bus.mem_ready) state_d = S_T0;
        end else begin
          bus.MDRout = 1'b1;
          bus.Gra    = 1'b1;
          bus.Rin    = 1'b1;
          state_d    = S_T0;
        end
      end
      S_HALT: bus.halted = 1'b1;
      default: state_d = S_RESET;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// tb/tb_control_sequencer.sv - scoreboard bench for control_sequencer with an instruction-level reference model
module tb_control_sequencer;
  logic clock = 1'b0;
  logic clear = 1'b1;

  control_sequencer_if #(.IR_W(32), .ALU_W(5)) bus();
  control_sequencer dut (.clock(clock), .clear(clear), .bus(bus));

  always #5 clock = ~clock;

  localparam logic [27:0] M_PCOUT  = 28'd1 << 27;
  localparam logic [27:0] M_INCPC  = 28'd1 << 26;
  localparam logic [27:0] M_MARIN  = 28'd1 << 25;
  localparam logic [27:0] M_MDRIN  = 28'd1 << 24;
  localparam logic [27:0] M_MDROUT = 28'd1 << 23;
  localparam logic [27:0] M_IRIN   = 28'd1 << 22;
  localparam logic [27:0] M_YIN    = 28'd1 << 21;
  localparam logic [27:0] M_COUT   = 28'd1 << 20;
  localparam logic [27:0] M_ZLOIN  = 28'd1 << 19;
  localparam logic [27:0] M_ZLOOUT = 28'd1 << 18;
  localparam logic [27:0] M_ZMUX   = 28'd1 << 17;
  localparam logic [27:0] M_GRA    = 28'd1 << 15;
  localparam logic [27:0] M_GRB    = 28'd1 << 14;
  localparam logic [27:0] M_GRC    = 28'd1 << 13;
  localparam logic [27:0] M_RIN    = 28'd1 << 12;
  localparam logic [27:0] M_ROUT   = 28'd1 << 11;
  localparam logic [27:0] M_BAOUT  = 28'd1 << 10;
  localparam logic [27:0] M_READ   = 28'd1 << 9;
  localparam logic [27:0] M_WRITE  = 28'd1 << 8;
  localparam logic [27:0] M_RAMEN  = 28'd1 << 7;
  localparam logic [27:0] M_HALTED = 28'd1 << 6;
  localparam logic [27:0] M_ILLEG  = 28'd1 << 5;

  typedef struct {
    logic        mr;
    logic        rn;
    logic [31:0] ir;
  } drv_t;

  typedef struct {
    logic [3:0]  st;
    logic [27:0] v;
  } exp_t;

  drv_t drv_q[$];
  exp_t exp_q[$];
  int   total   = 0;
  int   bad     = 0;
  int   issued  = 0;
  int   checked = 0;

  wire [27:0] dut_v = {bus.PCout, bus.IncPC, bus.MARin, bus.MDRin, bus.MDRout, bus.IRin,
                       bus.Yin, bus.Cout, bus.ZLOin, bus.ZLOout, bus.ZMuxEnable, bus.ZSelect,
                       bus.Gra, bus.Grb, bus.Grc, bus.Rin, bus.Rout, bus.BAout,
                       bus.read, bus.write, bus.RAMenable, bus.halted, bus.illegal,
                       bus.aluControl};

  function automatic logic rbit();
    return 1'($urandom);
  endfunction

  task automatic step(input logic [3:0] s, input logic [27:0] v, input logic mr,
                      input logic rn, input logic [31:0] i);
    drv_t d;
    exp_t e;
    d.mr = mr; d.rn = rn; d.ir = i;
    e.st = s;  e.v  = v;
    drv_q.push_back(d);
    exp_q.push_back(e);
  endtask

  // A memory cycle repeats with mem_ready low w times, then completes.
  task automatic mem_read(input logic [3:0] s, input int w);
    for (int k = 0; k < w; k++) step(s, M_READ | M_RAMEN, 1'b0, rbit(), $urandom);
    step(s, M_READ | M_RAMEN | M_MDRIN, 1'b1, rbit(), $urandom);
  endtask

  task automatic plan(input logic [31:0] instr, input int w1, input int wm,
                      input int idle, input int halt_cycles);
    logic [4:0] op;
    op = instr[31:27];
    for (int k = 0; k < idle; k++) step(4'd1, 28'd0, rbit(), 1'b0, $urandom);
    step(4'd1, M_PCOUT | M_INCPC | M_MARIN, rbit(), 1'b1, $urandom);
    mem_read(4'd2, w1);
    step(4'd3, M_MDROUT | M_IRIN, rbit(), rbit(), instr);
    if (op <= 5'd2) begin
      step(4'd4, M_GRB | M_BAOUT | M_YIN, rbit(), rbit(), $urandom);
      step(4'd5, M_COUT | M_ZMUX | M_ZLOIN | 28'd3, rbit(), rbit(), $urandom);
      if (op == 5'd1) begin
        step(4'd6, M_ZLOOUT | M_GRA | M_RIN, rbit(), rbit(), $urandom);
      end else begin
        step(4'd6, M_ZLOOUT | M_MARIN, rbit(), rbit(), $urandom);
        if (op == 5'd0) begin
          mem_read(4'd7, wm);
          step(4'd8, M_MDROUT | M_GRA | M_RIN, rbit(), rbit(), $urandom);
        end else begin
          step(4'd7, M_GRA | M_ROUT | M_MDRIN, rbit(), rbit(), $urandom);
          for (int k = 0; k < wm; k++) step(4'd8, M_WRITE | M_RAMEN, 1'b0, rbit(), $urandom);
          step(4'd8, M_WRITE | M_RAMEN, 1'b1, rbit(), $urandom);
        end
      end
    end else if (op <= 5'd12) begin
      step(4'd4, M_GRB | M_ROUT | M_YIN, rbit(), rbit(), $urandom);
      step(4'd5, M_GRC | M_ROUT | M_ZMUX | M_ZLOIN | 28'(op), rbit(), rbit(), $urandom);
      step(4'd6, M_ZLOOUT | M_GRA | M_RIN, rbit(), rbit(), $urandom);
    end else if (op == 5'd27) begin
      step(4'd4, 28'd0, rbit(), rbit(), $urandom);
      for (int k = 0; k < halt_cycles; k++) step(4'd9, M_HALTED, rbit(), 1'b1, $urandom);
    end else begin
      step(4'd4, M_ILLEG, rbit(), rbit(), $urandom);
    end
  endtask

  task automatic drain();
    int g;
    g = 0;
    while ((drv_q.size() != 0 || checked != issued) && g < 20000) begin
      @(negedge clock);
      g++;
    end
    if (g >= 20000) begin
      total++; bad++;
      $display("FAIL drain timeout: pending=%0d required=0", drv_q.size());
    end
  endtask

  task automatic check_zero(input string tag);
    total += 2;
    if (bus.state !== 4'd0) begin
      bad++;
      $display("FAIL %s state: got=%0d required=0", tag, bus.state);
    end
    if (dut_v !== 28'd0) begin
      bad++;
      $display("FAIL %s outputs: got=%h required=0000000", tag, dut_v);
    end
  endtask

  initial begin : driver
    drv_t d;
    bus.run       = 1'b0;
    bus.ir        = 32'd0;
    bus.mem_ready = 1'b0;
    forever begin
      @(posedge clock);
      #1;
      if (drv_q.size() != 0) begin
        d = drv_q.pop_front();
        bus.mem_ready = d.mr;
        bus.run       = d.rn;
        bus.ir        = d.ir;
        issued++;
      end else begin
        bus.run       = 1'b0;
        bus.mem_ready = rbit();
        bus.ir        = $urandom;
      end
    end
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clock);
      if (checked < issued && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        checked++;
        total += 2;
        if (bus.state !== e.st) begin
          bad++;
          $display("FAIL state cyc=%0d: got=%0d required=%0d", checked, bus.state, e.st);
        end
        if (dut_v !== e.v) begin
          bad++;
          $display("FAIL ctrl cyc=%0d state=%0d: got=%h required=%h", checked, e.st, dut_v, e.v);
        end
      end
    end
  end

  initial begin : main
    logic [4:0] op;
    int base;
    int g;
    clear = 1'b1;
    repeat (2) @(negedge clock);
    check_zero("reset");
    clear = 1'b0;

    plan(32'h01080045, 0, 0, 0, 0);
    plan(32'h1A920000, 0, 0, 0, 0);
    plan(32'h11800087, 0, 3, 0, 0);
    plan(32'h08400012, 2, 0, 1, 0);
    plan(32'hF8000000, 0, 0, 0, 0);
    for (int n = 0; n < 40; n++) begin
      do op = 5'($urandom_range(0, 31)); while (op == 5'd27);
      plan({op, 27'($urandom)}, $urandom_range(0, 3), $urandom_range(0, 3),
           $urandom_range(0, 2), 0);
    end
    drain();

    // Clear lands in the second wait cycle of an ld's data read.
    base = issued;
    plan(32'h01080045, 0, 4, 0, 0);
    g = 0;
    while (issued != base + 8 && g < 200) begin
      @(posedge clock);
      #2;
      g++;
    end
    if (g >= 200) begin
      total++; bad++;
      $display("FAIL ld wait timeout: issued=%0d required=%0d", issued - base, 8);
    end
    clear = 1'b1;
    #1;
    check_zero("clear_mid_ld");
    drv_q.delete();
    exp_q.delete();
    checked = issued;
    @(negedge clock);
    clear = 1'b0;
    plan(32'h08400012, 1, 0, 0, 0);
    plan(32'hD8000000, 0, 0, 0, 20);
    drain();

    @(posedge clock);
    #2;
    clear = 1'b1;
    #1;
    check_zero("clear_halt");
    @(negedge clock);
    clear = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
